// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and default sizing for the multi-port register
//                file. Holds the two-state controller encoding (clear / run)
//                and the default address and data widths.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

    // Controller state: CLEAR zeroes the array after reset, RUN is normal use.
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_sel
//  Description : Priority write selector for a single register. Scans every
//                write port and, among the enabled ports addressing this
//                register, picks the one with the highest index. Also reports
//                when two or more enabled ports hit this register at once.
//  Ports       : i_we     - per-write-port enable
//                i_addr   - packed write addresses, port i at slice i
//                i_data   - packed write data, port i at slice i
//                i_idx    - index of the register this instance serves
//                o_we     - at least one enabled port targets i_idx
//                o_data   - data of the highest-index matching port
//                o_multi  - two or more enabled ports target i_idx
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wr_sel
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int N_WR   = 2
) (
    input  logic [N_WR-1:0]        i_we,
    input  logic [N_WR*ADDR_W-1:0] i_addr,
    input  logic [N_WR*DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0]      i_idx,
    output logic                   o_we,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_multi
);

    // Ascending scan: a later (higher-index) match overwrites an earlier one,
    // which gives the highest port priority. A match seen while o_we is
    // already set means a second port collided on this register.
    always_comb begin
        o_we    = 1'b0;
        o_data  = '0;
        o_multi = 1'b0;
        for (int i = 0; i < N_WR; i++) begin
            if (i_we[i] && (i_addr[i*ADDR_W +: ADDR_W] == i_idx)) begin
                if (o_we) begin
                    o_multi = 1'b1;
                end
                o_we   = 1'b1;
                o_data = i_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule : rf_wr_sel
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : rf_multiport
//  Description : Multi-read / multi-write register file with a hardwired zero
//                register at address 0. After reset the array is zeroed one
//                register per cycle (addresses 1 .. 2^ADDR_W-1) before Ready
//                rises. Reads are combinational. Simultaneous writes to one
//                address resolve to the highest port index and raise a
//                one-cycle WrConflict pulse on the following cycle.
//  Config      : RF_BYPASS_EN - when defined, a read that matches an enabled
//                same-cycle write returns the write data (write-to-read
//                forwarding). Undefined by default: reads see stored data.
//  Ports       : Clk        - clock, rising edge
//                Rstn       - synchronous active-low reset
//                RdWe       - per-write-port enable        [N_WR]
//                RdAddr     - write addresses              [N_WR*ADDR_W]
//                RdData     - write data                   [N_WR*DATA_W]
//                RsAddr     - read addresses               [N_RD*ADDR_W]
//                RsData     - read data                    [N_RD*DATA_W]
//                Ready      - high once the post-reset clear is complete
//                WrConflict - one-cycle pulse after a same-address collision
//  Revision    : 1.0  initial release
// ============================================================================
module rf_multiport
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2
) (
    input  logic                   Clk,
    input  logic                   Rstn,
    input  logic [N_WR-1:0]        RdWe,
    input  logic [N_WR*ADDR_W-1:0] RdAddr,
    input  logic [N_WR*DATA_W-1:0] RdData,
    input  logic [N_RD*ADDR_W-1:0] RsAddr,
    output logic [N_RD*DATA_W-1:0] RsData,
    output logic                   Ready,
    output logic                   WrConflict
);

    localparam int                C_DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    rf_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_cnt;   // register being zeroed during CLEAR
    logic              r_conflict;

    // Per-register views of the storage and of the collision detectors.
    logic [DATA_W-1:0] w_mem   [C_DEPTH];
    logic [C_DEPTH-1:0] w_multi;
    logic              w_run;

    assign w_run      = (r_state == RF_RUN);
    assign Ready      = w_run;
    assign WrConflict = r_conflict;

    // Register 0 is not storage: it always reads zero and never collides.
    assign w_mem[0]   = '0;
    assign w_multi[0] = 1'b0;

    // The clear counter starts at 1 because register 0 needs no clearing;
    // the transition to RUN happens on the edge that zeroes the last register.
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            r_state    <= RF_CLEAR;
            r_clr_cnt  <= C_CNT_ONE;
            r_conflict <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_clr_cnt  <= r_clr_cnt + C_CNT_ONE;
                    r_conflict <= 1'b0;
                    if (r_clr_cnt == C_LAST) begin
                        r_state <= RF_RUN;
                    end
                end
                RF_RUN: begin
                    // Collisions on address 0 never reach a detector, so
                    // discarded writes cannot raise the flag.
                    r_conflict <= |w_multi;
                end
                default: begin
                    r_state    <= RF_CLEAR;
                    r_clr_cnt  <= C_CNT_ONE;
                    r_conflict <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: one register plus one priority selector per address 1..N-1
    // ------------------------------------------------------------------
    generate
        for (genvar k = 1; k < C_DEPTH; k++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(k);

            logic              w_we;
            logic [DATA_W-1:0] w_wdata;
            logic              w_hit_multi;
            logic [DATA_W-1:0] r_q;

            rf_wr_sel #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W),
                .N_WR   (N_WR)
            ) u_wr_sel (
                .i_we    (RdWe),
                .i_addr  (RdAddr),
                .i_data  (RdData),
                .i_idx   (c_idx),
                .o_we    (w_we),
                .o_data  (w_wdata),
                .o_multi (w_hit_multi)
            );

            // Storage is left untouched on the reset edge itself; clearing
            // starts on the first edge after Rstn is released. Write enables
            // are ignored while clearing.
            always_ff @(posedge Clk) begin
                if (Rstn) begin
                    if (r_state == RF_CLEAR) begin
                        if (r_clr_cnt == c_idx) begin
                            r_q <= '0;
                        end
                    end else if (w_we) begin
                        r_q <= w_wdata;
                    end
                end
            end

            assign w_mem[k]   = r_q;
            assign w_multi[k] = w_hit_multi;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports: combinational, forced to zero until the clear completes
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < N_RD; j++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rv;

            assign w_ra = RsAddr[j*ADDR_W +: ADDR_W];

            always_comb begin
                w_rv = w_mem[w_ra];
`ifdef RF_BYPASS_EN
                // Forward same-cycle write data; ascending scan keeps the
                // highest matching port, consistent with the write priority.
                for (int i = 0; i < N_WR; i++) begin
                    if (RdWe[i] && (RdAddr[i*ADDR_W +: ADDR_W] == w_ra) &&
                        (w_ra != '0)) begin
                        w_rv = RdData[i*DATA_W +: DATA_W];
                    end
                end
`endif
                if (!w_run) begin
                    w_rv = '0;
                end
            end

            assign RsData[j*DATA_W +: DATA_W] = w_rv;
        end
    endgenerate

endmodule : rf_multiport
`default_nettype wire

// File: tb/tb_rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_multiport
//  Description : Self-checking bench for rf_multiport (ADDR_W=4, DATA_W=32,
//                N_RD=2, N_WR=2). A behavioural model of the register file
//                (plain array plus clear-progress count) is compared with the
//                DUT on every falling edge; directed scenarios add literal
//                expectations, followed by a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_multiport;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int NREG = 1 << AW;

    logic              Clk;
    logic              Rstn;
    logic [NW-1:0]     RdWe;
    logic [NW*AW-1:0]  RdAddr;
    logic [NW*DW-1:0]  RdData;
    logic [NR*AW-1:0]  RsAddr;
    logic [NR*DW-1:0]  RsData;
    logic              Ready;
    logic              WrConflict;

    int total = 0;
    int bad   = 0;

    rf_multiport #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .N_RD   (NR),
        .N_WR   (NW)
    ) dut (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .RdWe       (RdWe),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .RsAddr     (RsAddr),
        .RsData     (RsData),
        .Ready      (Ready),
        .WrConflict (WrConflict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [NREG];
    bit            m_valid = 1'b0;   // set once the first reset has been seen
    bit            m_run   = 1'b0;
    int            m_clr   = 1;      // next register the clear will zero
    bit            m_conf  = 1'b0;

    initial begin
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    end

    always @(posedge Clk) begin
        int hits [NREG];
        bit coll;
        if (!Rstn) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_clr   <= 1;
            m_conf  <= 1'b0;
        end else if (m_valid) begin
            if (!m_run) begin
                m_mem[m_clr] <= '0;
                m_clr        <= m_clr + 1;
                m_run        <= (m_clr == NREG - 1);
                m_conf       <= 1'b0;
            end else begin
                for (int a = 0; a < NREG; a++) hits[a] = 0;
                for (int p = 0; p < NW; p++)
                    if (RdWe[p]) hits[RdAddr[p*AW +: AW]] += 1;
                coll = 1'b0;
                for (int a = 1; a < NREG; a++)
                    if (hits[a] > 1) coll = 1'b1;
                m_conf <= coll;
                // Ascending order: the last nonblocking write (highest port) wins.
                for (int p = 0; p < NW; p++)
                    if (RdWe[p] && RdAddr[p*AW +: AW] != 0)
                        m_mem[RdAddr[p*AW +: AW]] <= RdData[p*DW +: DW];
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (!m_run || a == 0) return '0;
        v = m_mem[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (RdWe[p] && RdAddr[p*AW +: AW] == a) v = RdData[p*DW +: DW];
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (m_valid) begin
            chk("ready", 64'(Ready), 64'(m_run));
            chk("wrconflict", 64'(WrConflict), 64'(m_conf));
            for (int j = 0; j < NR; j++)
                chk($sformatf("rsdata%0d", j), 64'(RsData[j*DW +: DW]),
                    64'(exp_rd(RsAddr[j*AW +: AW])));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        RdWe[p]           = we;
        RdAddr[p*AW +: AW] = a;
        RdData[p*DW +: DW] = d;
    endtask

    task automatic rand_wr();
        for (int p = 0; p < NW; p++)
            set_wr(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG-1)), $urandom);
        for (int j = 0; j < NR; j++)
            RsAddr[j*AW +: AW] = AW'($urandom_range(0, NREG-1));
    endtask

    // Counts edges until Ready rises, optionally with random traffic; bounded.
    task automatic wait_ready(input bit noisy, output int n);
        n = 0;
        while (!Ready && n < 40) begin
            if (noisy) rand_wr();
            tick();
            n++;
        end
        RdWe = '0;
    endtask

    task automatic pulse_reset();
        Rstn = 1'b0;
        tick();
        Rstn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed scenarios, then random traffic
    // ------------------------------------------------------------------
    initial begin
        int n;
        Rstn   = 1'b0;
        RdWe   = '0;
        RdAddr = '0;
        RdData = '0;
        RsAddr = '0;
        tick();
        chk("reset_ready", 64'(Ready), 64'd0);
        chk("reset_conflict", 64'(WrConflict), 64'd0);
        Rstn = 1'b1;
        wait_ready(1'b0, n);
        chk("first_clear_len", 64'(n), 64'd15);

        // Preload then reset: the clear must wipe it and ignore writes.
        set_wr(0, 1'b1, 4'd5, 32'hDEAD);
        tick();
        RdWe = '0;
        RsAddr[0 +: AW] = 4'd5;
        #1 chk("preload_reg5", 64'(RsData[0 +: DW]), 64'h0000_DEAD);
        pulse_reset();
        wait_ready(1'b1, n);
        chk("clear_len", 64'(n), 64'd15);
        for (int a = 0; a < NREG; a += 5) begin
            RsAddr[0 +: AW] = AW'(a);
            #1 chk($sformatf("cleared_reg%0d", a), 64'(RsData[0 +: DW]), 64'd0);
        end

        // Same-address collision: highest port wins, one-cycle flag.
        set_wr(0, 1'b1, 4'd3, 32'h11);
        set_wr(1, 1'b1, 4'd3, 32'h22);
        tick();
        RdWe = '0;
        RsAddr[AW +: AW] = 4'd3;
        #1 chk("collide_val", 64'(RsData[DW +: DW]), 64'h22);
        chk("collide_flag", 64'(WrConflict), 64'd1);
        tick();
        chk("collide_flag_drop", 64'(WrConflict), 64'd0);

        // Write to address 0 is discarded and never flags.
        set_wr(1, 1'b1, 4'd0, 32'hFFFF_FFFF);
        set_wr(0, 1'b1, 4'd0, 32'h1234);
        RsAddr[0 +: AW] = 4'd0;
        tick();
        RdWe = '0;
        chk("zero_reg", 64'(RsData[0 +: DW]), 64'd0);
        chk("zero_noflag", 64'(WrConflict), 64'd0);

        // Read/write of the same register in one cycle.
        set_wr(0, 1'b1, 4'd7, 32'hA5);
        RsAddr[0 +: AW] = 4'd7;
`ifdef RF_BYPASS_EN
        #1 chk("rw_same_cycle", 64'(RsData[0 +: DW]), 64'hA5);
`else
        #1 chk("rw_same_cycle", 64'(RsData[0 +: DW]), 64'h0);
`endif
        tick();
        RdWe = '0;
        #1 chk("rw_next_cycle", 64'(RsData[0 +: DW]), 64'hA5);

        // Reset in the middle of clearing restarts the full sequence.
        pulse_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("midclear_ready", 64'(Ready), 64'd0);
        pulse_reset();
        wait_ready(1'b0, n);
        chk("restart_clear_len", 64'(n), 64'd15);
        RsAddr[0 +: AW] = 4'd7;
        #1 chk("restart_reg7", 64'(RsData[0 +: DW]), 64'd0);

        // Disjoint writes on both ports.
        set_wr(0, 1'b1, 4'd2, 32'h1);
        set_wr(1, 1'b1, 4'd9, 32'h2);
        tick();
        RdWe = '0;
        chk("disjoint_noflag", 64'(WrConflict), 64'd0);
        RsAddr[0 +: AW]  = 4'd2;
        RsAddr[AW +: AW] = 4'd9;
        #1 chk("disjoint_rd0", 64'(RsData[0 +: DW]), 64'h1);
        chk("disjoint_rd1", 64'(RsData[DW +: DW]), 64'h2);
        RsAddr[0 +: AW]  = 4'd9;
        RsAddr[AW +: AW] = 4'd2;
        #1 chk("disjoint_rd0b", 64'(RsData[0 +: DW]), 64'h2);
        chk("disjoint_rd1b", 64'(RsData[DW +: DW]), 64'h1);

        // Randomized traffic with narrow address ranges to provoke collisions
        // and occasional resets; the per-cycle compare does the checking.
        for (int c = 0; c < 800; c++) begin
            Rstn = ($urandom_range(0, 249) != 0);
            for (int p = 0; p < NW; p++)
                set_wr(p, 1'($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3))
                                                   : AW'($urandom_range(0, NREG-1)),
                       $urandom);
            for (int j = 0; j < NR; j++)
                RsAddr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3))
                                                                 : AW'($urandom_range(0, NREG-1));
            tick();
        end
        Rstn = 1'b1;
        RdWe = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_multiport
`default_nettype wire
